// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Purpose  : Sums blocks of COUNT unsigned 2*WIDTH-bit products arriving over
//            a valid/ready handshake. A flush pulse closes a partial block
//            early. Each finished sum sits in a held output register with
//            its own valid/ready handshake, so the producer keeps streaming
//            while the previous sum drains.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            in_valid   - product valid
//            in_ready   - block can take a product (registered state only)
//            in_data    - unsigned product, 2*WIDTH bits
//            flush      - single-cycle request to close the current block
//            out_valid  - out_data / out_count valid
//            out_ready  - downstream takes the sum
//            out_data   - block sum, OUT_WIDTH bits
//            out_count  - products in the block, 1..COUNT
// Options  : PRODUCT_ACC_SAT_EN - when defined and OUT_WIDTH is narrower than
//            the accumulator, oversize sums saturate to all ones; otherwise
//            the low OUT_WIDTH bits are kept.
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int CW        = $clog2(COUNT) + 1,
    parameter int OUT_WIDTH = 2 * WIDTH + $clog2(COUNT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CW-1:0]        out_count
);

    // Wide enough for COUNT full-scale products, so it can never overflow.
    localparam int          c_ACC_W = 2 * WIDTH + $clog2(COUNT);
    localparam logic [CW-1:0] c_LAST = CW'(COUNT - 1);

    logic [c_ACC_W-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_flush_pend;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [CW-1:0]        r_out_count;

    logic                 w_accept;
    logic                 w_freq;
    logic                 w_has_samples;
    logic                 w_close;
    logic [c_ACC_W-1:0]   w_sum;
    logic [CW-1:0]        w_total;
    logic [OUT_WIDTH-1:0] w_out;

    // Ready is derived purely from registers: it drops when the last slot of
    // a block would need an occupied output register, or while a flush waits.
    assign in_ready      = !(r_out_valid && (r_cnt == c_LAST)) && !r_flush_pend;
    assign w_accept      = in_valid && in_ready;
    assign w_freq        = flush || r_flush_pend;
    // The block is non-empty once this cycle's product is counted.
    assign w_has_samples = (r_cnt != '0) || w_accept;
    assign w_close       = !r_out_valid &&
                           ((w_accept && (r_cnt == c_LAST)) || (w_freq && w_has_samples));

    // Running totals including the product accepted this cycle, if any.
    assign w_sum   = r_acc + (w_accept ? c_ACC_W'(in_data) : '0);
    assign w_total = r_cnt + CW'(w_accept);

    generate
        if (OUT_WIDTH < c_ACC_W) begin : g_narrow
`ifdef PRODUCT_ACC_SAT_EN
            assign w_out = (|w_sum[c_ACC_W-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                         : w_sum[OUT_WIDTH-1:0];
`else
            assign w_out = w_sum[OUT_WIDTH-1:0];
`endif
        end else begin : g_wide
            assign w_out = OUT_WIDTH'(w_sum);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_count  <= '0;
        end else if (w_close) begin
            // Closing is only possible with the output register empty, so no
            // drain can coincide with it.
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b1;
            r_out_data   <= w_out;
            r_out_count  <= w_total;
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= w_total;
            end
            // A flush that could not close (output still held) is remembered;
            // a flush on an empty block with nothing arriving is dropped.
            if (w_freq && w_has_samples) begin
                r_flush_pend <= 1'b1;
            end
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Purpose  : Scoreboard bench for product_accumulator. Each test pushes the
//            sums it expects; a monitor pops one entry per output handshake.
//            A second instance with OUT_WIDTH=16 runs on the same stimulus to
//            exercise the narrowed output (saturating or wrapping).
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    localparam int WIDTH  = 8;
    localparam int COUNT  = 4;
    localparam int CW     = $clog2(COUNT) + 1;
    localparam int OW     = 2 * WIDTH + $clog2(COUNT);
    localparam int OW_N   = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        out_data;
    logic [CW-1:0]        out_count;

    logic                 in_ready_n;
    logic                 out_valid_n;
    logic [OW_N-1:0]      out_data_n;
    logic [CW-1:0]        out_count_n;

    typedef struct {
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    product_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    product_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .OUT_WIDTH(OW_N)) u_dut_n (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_data(in_data), .flush(flush), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_data(out_data_n), .out_count(out_count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] narrow_exp(input logic [31:0] sum);
`ifdef PRODUCT_ACC_SAT_EN
        return (sum > 32'd65535) ? 32'd65535 : sum;
`else
        return sum & 32'hFFFF;
`endif
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic [31:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    // Monitor: evaluate the handshake at the falling edge, where inputs and
    // outputs are stable ahead of the rising edge that completes it.
    logic        mon_prev_valid = 1'b0;
    logic [31:0] mon_prev_data  = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_prev_valid = 1'b0;
        end else begin
            if (mon_prev_valid && out_valid)
                check("hold_data", 32'(out_data), mon_prev_data);
            mon_prev_valid = out_valid && !out_ready;
            mon_prev_data  = 32'(out_data);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data",    32'(out_data),    e.data);
                    check("out_count",   32'(out_count),   e.cnt);
                    check("narrow_valid", 32'(out_valid_n), 32'd1);
                    check("narrow_data", 32'(out_data_n),  narrow_exp(e.data));
                end
            end
        end
    end

    // Presents one product (optionally with flush) and returns one cycle
    // after it is accepted, aligned #1 after the rising edge.
    task automatic send(input logic [15:0] d, input logic fl);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Full block
        out_ready = 1'b1;
        push_exp(100, 4);
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        wait_empty();
        @(negedge clk);
        check("one_cycle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Max values
        push_exp(260100, 4);
        for (int i = 0; i < 4; i++) send(16'd65025, 0);
        wait_empty();

        // Backpressure
        out_ready = 1'b0;
        push_exp(4, 4);
        push_exp(4, 4);
        for (int i = 0; i < 7; i++) send(1, 0);
        repeat (3) @(negedge clk);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_held_data", 32'(out_data),  32'd4);
        fork
            send(1, 0);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();

        // Flush after two products, flush with a product, flush when empty
        push_exp(15, 2);
        send(7, 0); send(8, 0);
        flush_pulse();
        wait_empty();
        push_exp(5, 1);
        send(5, 1);
        wait_empty();
        flush_pulse();
        repeat (4) @(negedge clk);
        check("empty_flush", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Pending flush behind an undrained sum
        out_ready = 1'b0;
        push_exp(4, 4);
        push_exp(3, 1);
        for (int i = 0; i < 4; i++) send(1, 0);
        send(3, 0);
        flush_pulse();
        @(negedge clk);
        check("pend_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty();

        // Reset mid-block
        send(1, 0); send(1, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        push_exp(4, 4);
        for (int i = 0; i < 4; i++) send(1, 0);
        wait_empty();

        // Narrow output on max products
        push_exp(260100, 4);
        for (int i = 0; i < 4; i++) send(16'd65025, 0);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
